bcd_conv_sched: RTL

Scheduler that time-shares one 8-bit binary-to-BCD converter (2-digit, bit-serial, fixed latency) among the three clock fields: seconds, minutes and hours.
- On each update request it snapshots the three binary fields.
- It feeds them to the converter one at a time, collects each 2-digit BCD result and publishes a packed 24-bit BCD time word with a one-cycle valid pulse.
- It sits between the time-keeping counters and the display/encoding path of the data clock.

---
 rtl/bcd_conv_sched_pkg.sv | 23 ++
 rtl/bcd_conv_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched_pkg.sv
// Shared definitions for the BCD conversion scheduler: FSM encoding,
// channel indices, clamp limit and default converter latency.
package bcd_conv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [1:0] ch_t;

  localparam ch_t CH_SEC  = 2'd0;
  localparam ch_t CH_MIN  = 2'd1;
  localparam ch_t CH_HOUR = 2'd2;

  localparam logic [6:0] CLAMP_MAX = 7'd99;

  // 1-cycle operand latch + 8 shift cycles + 1 output register
  localparam int CNV_LAT_DEF = 10;

endpackage

// File: rtl/bcd_conv_sched.sv
// Time-shares one 2-digit binary-to-BCD converter across sec/min/hour and
// publishes a packed 24-bit BCD time word with a one-cycle valid pulse.
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int CNV_LAT = CNV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd,
  input  logic [6:0]  sec_bin,
  input  logic [6:0]  min_bin,
  input  logic [6:0]  hour_bin,
  output logic        cnv_vld,
  output logic [7:0]  cnv_bin,
  input  logic [7:0]  cnv_bcd,
  output logic [23:0] bcd_time,
  output logic        bcd_vld,
  output logic        busy,
  output logic        bcd_err
);

  localparam int WCNT_W = $clog2(CNV_LAT);

  function automatic logic [6:0] clamp(input logic [6:0] v);
    return (v > CLAMP_MAX) ? CLAMP_MAX : v;
  endfunction

  state_t              state_reg, state_next;
  ch_t                 ch_reg;
  logic [WCNT_W-1:0]   wcnt_reg;
  logic [6:0]          snap_reg      [0:2];
  logic                snap_err_reg;
  logic                pend_reg;
  logic [6:0]          pend_snap_reg [0:2];
  logic                pend_err_reg;
  logic [7:0]          result_reg    [0:1];
  logic [23:0]         bcd_time_reg;
  logic                bcd_err_reg;

  logic [6:0]          fields_in  [0:2];
  logic [6:0]          fields_clr [0:2];
  logic [2:0]          field_over;
  logic                in_err;
  logic                last_wait;

  assign fields_in[0] = sec_bin;
  assign fields_in[1] = min_bin;
  assign fields_in[2] = hour_bin;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_clamp
      assign fields_clr[gi] = clamp(fields_in[gi]);
      assign field_over[gi] = (fields_in[gi] > CLAMP_MAX);
    end
  endgenerate

  assign in_err    = |field_over;
  assign last_wait = (state_reg == ST_WAIT) && (wcnt_reg == WCNT_W'(CNV_LAT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (upd) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (last_wait) state_next = (ch_reg == CH_HOUR) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_next = (upd || pend_reg) ? ST_ISSUE : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    cnv_vld = 1'b0;
    cnv_bin = 8'd0;
    bcd_vld = (state_reg == ST_DONE);
    busy    = (state_reg != ST_IDLE);
    if (state_reg == ST_ISSUE) begin
      cnv_vld = 1'b1;
      case (ch_reg)
        CH_MIN:  cnv_bin = {1'b0, snap_reg[1]};
        CH_HOUR: cnv_bin = {1'b0, snap_reg[2]};
        default: cnv_bin = {1'b0, snap_reg[0]};
      endcase
    end
  end

  assign bcd_time = bcd_time_reg;
  assign bcd_err  = bcd_err_reg;

  // Datapath: snapshots, pending request, wait counter and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_reg       <= CH_SEC;
      wcnt_reg     <= '0;
      snap_err_reg <= 1'b0;
      pend_reg     <= 1'b0;
      pend_err_reg <= 1'b0;
      bcd_time_reg <= 24'd0;
      bcd_err_reg  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        snap_reg[i]      <= '0;
        pend_snap_reg[i] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        result_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (upd) begin
            for (int i = 0; i < 3; i++) snap_reg[i] <= fields_clr[i];
            snap_err_reg <= in_err;
            ch_reg       <= CH_SEC;
          end
        end
        ST_ISSUE: begin
          wcnt_reg <= '0;
        end
        ST_WAIT: begin
          wcnt_reg <= wcnt_reg + WCNT_W'(1);
          if (last_wait) begin
            if (ch_reg == CH_HOUR) begin
              bcd_time_reg <= {cnv_bcd, result_reg[1], result_reg[0]};
              bcd_err_reg  <= snap_err_reg;
            end else begin
              result_reg[ch_reg[0]] <= cnv_bcd;
              ch_reg                <= ch_reg + 2'd1;
            end
          end
        end
        ST_DONE: begin
          // A request in the DONE cycle itself overrides any older pending one
          ch_reg   <= CH_SEC;
          pend_reg <= 1'b0;
          if (upd) begin
            for (int i = 0; i < 3; i++) snap_reg[i] <= fields_clr[i];
            snap_err_reg <= in_err;
          end else if (pend_reg) begin
            for (int i = 0; i < 3; i++) snap_reg[i] <= pend_snap_reg[i];
            snap_err_reg <= pend_err_reg;
          end
        end
        default: ;
      endcase

      if (upd && (state_reg == ST_ISSUE || state_reg == ST_WAIT)) begin
        for (int i = 0; i < 3; i++) pend_snap_reg[i] <= fields_clr[i];
        pend_err_reg <= in_err;
        pend_reg     <= 1'b1;
      end
    end
  end

endmodule
